// File: rtl/inst_mem_dumper_pkg.sv
// Shared types and helpers for the byte-serial memory dumper and its loader counterpart.
// Defining INST_MEM_DUMPER_CHECKSUM_EN adds a trailing XOR checksum state.
package inst_mem_dumper_pkg;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_LANE      = 2'(BYTES_PER_WORD - 1);

`ifdef INST_MEM_DUMPER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WT   = 3'd2,
        ST_SEND = 3'd3,
        ST_FIN  = 3'd4,
        ST_CSUM = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WT   = 3'd2,
        ST_SEND = 3'd3,
        ST_FIN  = 3'd4
    } state_e;
`endif

    // Lane i of a word is bits [8i+7:8i]; lane 0 is the first byte on the wire.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/inst_mem_dumper_byte_serializer.sv
// Loads a 32-bit word and emits it LSB-first as bytes on a valid/ready stream.
// last_idx selects how many bytes of the word are sent (3 = full word, 0 = single byte).
module inst_mem_dumper_byte_serializer
    import inst_mem_dumper_pkg::*;
(
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [1:0]  last_idx,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        xfer,
    output logic        last
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  last_q, last_d;
    logic        valid_q, valid_d;

    assign xfer     = valid_q & tx_ready;
    assign last     = (idx_q == last_q);
    assign tx_valid = valid_q;
    assign tx_data  = byte_lane(shift_q, 2'd0);

    // Load has priority so a new word can follow the final byte back-to-back.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (load) begin
            shift_d = load_data;
            idx_d   = 2'd0;
            last_d  = last_idx;
            valid_d = 1'b1;
        end else if (xfer) begin
            shift_d = {8'h00, shift_q[31:8]};
            idx_d   = idx_q + 2'd1;
            if (idx_q == last_q) begin
                valid_d = 1'b0;
            end else begin
                valid_d = 1'b1;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Byte buffer and handshake state.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            shift_q <= 32'h0000_0000;
            idx_q   <= 2'd0;
            last_q  <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/inst_mem_dumper.sv
// Byte-serial read-back engine: reads count words from start_addr and streams them LSB-first.
// Defining INST_MEM_DUMPER_CHECKSUM_EN appends an XOR checksum byte after the last word.
module inst_mem_dumper
    import inst_mem_dumper_pkg::*;
#(
    parameter int MEM_WIDTH = 2
)
(
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 start,
    input  logic [MEM_WIDTH-1:0] start_addr,
    input  logic [MEM_WIDTH:0]   count,
    output logic [MEM_WIDTH-1:0] mem_addr,
    input  logic [31:0]          mem_rdata,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = MEM_WIDTH + 1;

    state_e               state_q, state_d;
    logic [MEM_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]        rem_q, rem_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 ser_load_s;
    logic [31:0]          ser_data_s;
    logic [1:0]           ser_last_idx_s;
    logic                 ser_xfer_s;
    logic                 ser_last_s;
    logic [7:0]           tx_data_s;
`ifdef INST_MEM_DUMPER_CHECKSUM_EN
    logic [7:0]           csum_q, csum_d;
`endif

    assign mem_addr = addr_q;
    assign tx_data  = tx_data_s;
    assign busy     = busy_q;
    assign done     = done_q;

    inst_mem_dumper_byte_serializer u_ser (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .load      (ser_load_s),
        .load_data (ser_data_s),
        .last_idx  (ser_last_idx_s),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data_s),
        .tx_valid  (tx_valid),
        .xfer      (ser_xfer_s),
        .last      (ser_last_s)
    );

    // Next-state and control; the serializer is loaded in WT, when mem_rdata holds the word.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        rem_d          = rem_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        ser_load_s     = 1'b0;
        ser_data_s     = mem_rdata;
        ser_last_idx_s = LAST_LANE;
`ifdef INST_MEM_DUMPER_CHECKSUM_EN
        if (ser_xfer_s && (state_q == ST_SEND)) begin
            csum_d = csum_q ^ tx_data_s;
        end else begin
            csum_d = csum_q;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef INST_MEM_DUMPER_CHECKSUM_EN
                    csum_d = 8'h00;
`endif
                    if (count != {CW{1'b0}}) begin
                        addr_d  = start_addr;
                        rem_d   = count;
                        busy_d  = 1'b1;
                        state_d = ST_RD;
                    end else begin
`ifdef INST_MEM_DUMPER_CHECKSUM_EN
                        busy_d         = 1'b1;
                        ser_load_s     = 1'b1;
                        ser_data_s     = 32'h0000_0000;
                        ser_last_idx_s = 2'd0;
                        state_d        = ST_CSUM;
`else
                        state_d = ST_FIN;
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                state_d = ST_WT;
            end
            ST_WT: begin
                ser_load_s = 1'b1;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (ser_xfer_s && ser_last_s) begin
                    addr_d = addr_q + MEM_WIDTH'(1);
                    rem_d  = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
`ifdef INST_MEM_DUMPER_CHECKSUM_EN
                        // Fold in the byte leaving on this edge so the checksum is complete.
                        ser_load_s     = 1'b1;
                        ser_data_s     = {24'h00_0000, csum_q ^ tx_data_s};
                        ser_last_idx_s = 2'd0;
                        state_d        = ST_CSUM;
`else
                        state_d = ST_FIN;
`endif
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
`ifdef INST_MEM_DUMPER_CHECKSUM_EN
            ST_CSUM: begin
                if (ser_xfer_s) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_CSUM;
                end
            end
`endif
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            addr_q  <= {MEM_WIDTH{1'b0}};
            rem_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef INST_MEM_DUMPER_CHECKSUM_EN
    // Running XOR of transmitted data bytes.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

endmodule

// File: tb/tb_inst_mem_dumper.sv
// Scoreboard bench for inst_mem_dumper: a reference model queues expected bytes, a monitor checks the stream.
module tb_inst_mem_dumper;

    localparam int MW    = 2;
    localparam int DEPTH = 4;

    logic          CLK;
    logic          RSTN;
    logic          start;
    logic [MW-1:0] start_addr;
    logic [MW:0]   count;
    logic [MW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          done;

    inst_mem_dumper #(.MEM_WIDTH(MW)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done)
    );

    logic [31:0] mem [DEPTH];
    logic [7:0]  exp_q [$];
    int          tests      = 0;
    int          fails      = 0;
    int          done_cnt   = 0;
    int          xfer_cnt   = 0;
    int          ready_mode = 0;
    int          cyc_cnt    = 0;
    bit          stall_prev = 1'b0;
    logic [7:0]  stall_data = 8'h00;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Registered-read memory.
    always @(posedge CLK) mem_rdata <= mem[mem_addr];

    // Sink ready pattern: 0 = always, 1 = one cycle in three, other = random.
    always @(posedge CLK) begin
        #1;
        cyc_cnt = cyc_cnt + 1;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ((cyc_cnt % 3) == 0);
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and checks hold-while-stalled.
    always @(negedge CLK) begin
        if (RSTN) begin
            if (done) done_cnt++;
            if (stall_prev) begin
                tests++;
                if (tx_valid !== 1'b1 || tx_data !== stall_data) begin
                    fails++;
                    $display("FAIL hold: valid=%0b data=%02h, required valid=1 data=%02h",
                             tx_valid, tx_data, stall_data);
                end
            end
            if (tx_valid && tx_ready) begin
                xfer_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL extra_byte: got %02h, required no byte", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        fails++;
                        $display("FAIL byte: got %02h, required %02h", tx_data, e);
                    end
                end
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Reference model: the words of the dump, each split LSB-first, plus optional XOR byte.
    task automatic push_dump(input int sa, input int cnt);
        logic [7:0] x;
        logic [31:0] w;
        logic [7:0] b;
        x = 8'h00;
        for (int i = 0; i < cnt; i++) begin
            w = mem[(sa + i) % DEPTH];
            for (int k = 0; k < 4; k++) begin
                b = 8'((w >> (8 * k)) & 32'hff);
                exp_q.push_back(b);
                x = x ^ b;
            end
        end
`ifdef INST_MEM_DUMPER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic go(input int sa, input int cnt, input bit poke);
        int  d0;
        bit  got;
        @(posedge CLK); #2;
        d0         = done_cnt;
        start      = 1'b1;
        start_addr = MW'(sa);
        count      = (MW+1)'(cnt);
        @(posedge CLK); #2;
        start = 1'b0;
        if (cnt != 0) begin
            check("lat_c1_valid", tx_valid, 1'b0);
            check("busy_c1", busy, 1'b1);
            @(posedge CLK); #2;
            check("lat_c2_valid", tx_valid, 1'b0);
            @(posedge CLK); #2;
            check("lat_c3_valid", tx_valid, 1'b1);
            if (poke) begin
                start      = 1'b1;
                start_addr = MW'(sa + 1);
                count      = (MW+1)'(1);
                @(posedge CLK); #2;
                start = 1'b0;
            end
        end else begin
`ifndef INST_MEM_DUMPER_CHECKSUM_EN
            check("zero_done_c1", done, 1'b0);
            check("zero_valid_c1", tx_valid, 1'b0);
            @(posedge CLK); #2;
            check("zero_done_c2", done, 1'b1);
`endif
        end
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge CLK); #2;
        end
        check("done_seen", got, 1'b1);
        check("busy_at_done", busy, 1'b0);
        @(posedge CLK); #2;
        check("done_one_cycle", done, 1'b0);
        repeat (3) @(posedge CLK);
        #2;
        check("bytes_left", exp_q.size(), 0);
        check("done_pulses", done_cnt - d0, 1);
    endtask

    initial begin
        logic [7:0] img_bytes [16];
        int         x0;
        int         d0;
        mem[0] = 32'hec00_0000;
        mem[1] = 32'hf000_0000;
        mem[2] = 32'h2000_0001;
        mem[3] = 32'hf000_0000;
        img_bytes = '{8'h00, 8'h00, 8'h00, 8'hec, 8'h00, 8'h00, 8'h00, 8'hf0,
                      8'h01, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'hf0};
        RSTN       = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        tx_ready   = 1'b0;
        #1;
        check("rst_valid", tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", tx_data, 8'h00);
        repeat (2) @(posedge CLK);
        #2;
        RSTN = 1'b1;

        // Whole image, sink always ready.
        ready_mode = 0;
        for (int i = 0; i < 16; i++) exp_q.push_back(img_bytes[i]);
`ifdef INST_MEM_DUMPER_CHECKSUM_EN
        exp_q.push_back(8'hcd);
`endif
        go(0, 4, 1'b0);

        // Same dump, sink ready one cycle in three, with an ignored start mid-dump.
        ready_mode = 1;
        for (int i = 0; i < 16; i++) exp_q.push_back(img_bytes[i]);
`ifdef INST_MEM_DUMPER_CHECKSUM_EN
        exp_q.push_back(8'hcd);
`endif
        go(0, 4, 1'b1);

        // Address wrap.
        ready_mode = 0;
        push_dump(3, 2);
        go(3, 2, 1'b0);

        // Empty dump.
        push_dump(0, 0);
        go(0, 0, 1'b0);

        // Reset after five bytes of a four-word dump.
        push_dump(0, 4);
        @(posedge CLK); #2;
        x0         = xfer_cnt;
        d0         = done_cnt;
        start      = 1'b1;
        start_addr = '0;
        count      = 3'd4;
        @(posedge CLK); #2;
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (xfer_cnt - x0 >= 5) break;
            @(posedge CLK); #2;
        end
        check("rst_mid_bytes", xfer_cnt - x0, 5);
        check("rst_mid_pre_valid", tx_valid, 1'b1);
        RSTN = 1'b0;
        #1;
        check("rst_mid_valid", tx_valid, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        exp_q.delete();
        repeat (3) @(posedge CLK);
        #2;
        RSTN = 1'b1;
        repeat (4) @(posedge CLK);
        #2;
        check("rst_mid_no_done", done_cnt - d0, 0);
        push_dump(1, 1);
        go(1, 1, 1'b0);

        // Random images, addresses, lengths and sink behaviour.
        for (int t = 0; t < 10; t++) begin
            int sa;
            int cnt;
            for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
            sa         = $urandom_range(0, DEPTH - 1);
            cnt        = $urandom_range(0, DEPTH);
            ready_mode = $urandom_range(0, 2);
            repeat (2) @(posedge CLK);
            push_dump(sa, cnt);
            go(sa, cnt, 1'(t % 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
